// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Purpose  : Writeback arbiter/sequencer for the register bank's single write
//            port. Accepts one execution-unit result per cycle (round-robin
//            over valid/ready handshakes), drives the regbank write, emits a
//            one-hot unlock mask and reports the retired tag. A flush drains
//            and discards every pending result.
// Ports    : clk, reset (sync, active-high)
//            req_valid/req_ready/req_addr/req_data/req_tag : per-unit results
//            flush, flush_tag                              : pipeline redirect
//            we, wr_addr, wr_data                          : regbank write
//            unlock                                        : one-hot, bit 0 never set
//            retire_valid, retire_tag, exp_tag             : retirement status
// Config   : define WB_TAG_ORDER_EN for in-order retirement by tag; when it is
//            undefined tags are ignored for eligibility and exp_tag reads 0.
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
    parameter int N_REQ = 4,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*5-1:0]     req_addr,
    input  logic [N_REQ*32-1:0]    req_data,
    input  logic [N_REQ*TAG_W-1:0] req_tag,
    input  logic                   flush,
    input  logic [TAG_W-1:0]       flush_tag,
    output logic                   we,
    output logic [4:0]             wr_addr,
    output logic [31:0]            wr_data,
    output logic [31:0]            unlock,
    output logic                   retire_valid,
    output logic [TAG_W-1:0]       retire_tag,
    output logic [TAG_W-1:0]       exp_tag
);

    localparam int         c_PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [0:0] c_S_RUN   = 1'b0;
    localparam logic [0:0] c_S_FLUSH = 1'b1;

    logic [0:0]         r_state;
    logic [c_PTR_W-1:0] r_rr_ptr;
    logic               r_we;
    logic [4:0]         r_wr_addr;
    logic [31:0]        r_wr_data;
    logic [31:0]        r_unlock;
    logic               r_retire_valid;
    logic [TAG_W-1:0]   r_retire_tag;

    logic [N_REQ-1:0]   w_elig;
    logic               w_grant_found;
    logic [c_PTR_W-1:0] w_grant_idx;
    int                 w_scan_int;
    logic [c_PTR_W-1:0] w_scan_idx;
    logic               w_accept;
    logic [4:0]         w_sel_addr;
    logic [31:0]        w_sel_data;
    logic [TAG_W-1:0]   w_sel_tag;

`ifdef WB_TAG_ORDER_EN
    logic [TAG_W-1:0]   r_exp_tag;

    generate
        for (genvar k = 0; k < N_REQ; k++) begin : g_elig
            assign w_elig[k] = req_valid[k] && (req_tag[k*TAG_W +: TAG_W] == r_exp_tag);
        end
    endgenerate

    // Flush has priority over an accept in the same cycle (the accept is
    // suppressed anyway), and a repeated flush simply reloads the tag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_exp_tag <= '0;
        end else if (flush) begin
            r_exp_tag <= flush_tag;
        end else if (w_accept) begin
            r_exp_tag <= r_exp_tag + 1'b1;
        end
    end

    assign exp_tag = r_exp_tag;
`else
    logic w_unused_flush_tag;

    generate
        for (genvar k = 0; k < N_REQ; k++) begin : g_elig
            assign w_elig[k] = req_valid[k];
        end
    endgenerate

    assign w_unused_flush_tag = ^flush_tag;
    assign exp_tag            = '0;
`endif

    // Round-robin search starting just above the last granted unit.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_scan_int    = 0;
        w_scan_idx    = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            w_scan_int = int'(r_rr_ptr) + i;
            if (w_scan_int >= N_REQ) begin
                w_scan_int = w_scan_int - N_REQ;
            end
            w_scan_idx = c_PTR_W'(w_scan_int);
            if (!w_grant_found && w_elig[w_scan_idx]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = w_scan_idx;
            end
        end
    end

    // Flush and reset both suppress the grant for the current cycle.
    assign w_accept = (r_state == c_S_RUN) && !reset && !flush && w_grant_found;

    always_comb begin
        req_ready  = '0;
        w_sel_addr = '0;
        w_sel_data = '0;
        w_sel_tag  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_grant_idx == c_PTR_W'(k)) begin
                w_sel_addr = req_addr[k*5 +: 5];
                w_sel_data = req_data[k*32 +: 32];
                w_sel_tag  = req_tag[k*TAG_W +: TAG_W];
            end
            if (!reset) begin
                if (r_state == c_S_FLUSH) begin
                    req_ready[k] = req_valid[k];
                end else begin
                    req_ready[k] = w_accept && (w_grant_idx == c_PTR_W'(k));
                end
            end
        end
    end

    // Outputs are single-cycle pulses: cleared every cycle unless an accept
    // reloads them. x0 results retire without touching the regbank.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= c_S_RUN;
            r_rr_ptr       <= c_PTR_W'(N_REQ - 1);
            r_we           <= 1'b0;
            r_wr_addr      <= '0;
            r_wr_data      <= '0;
            r_unlock       <= '0;
            r_retire_valid <= 1'b0;
            r_retire_tag   <= '0;
        end else begin
            r_we           <= 1'b0;
            r_wr_addr      <= '0;
            r_wr_data      <= '0;
            r_unlock       <= '0;
            r_retire_valid <= 1'b0;
            r_retire_tag   <= '0;
            case (r_state)
                c_S_RUN: begin
                    if (flush) begin
                        r_state <= c_S_FLUSH;
                    end else if (w_accept) begin
                        r_rr_ptr       <= w_grant_idx;
                        r_retire_valid <= 1'b1;
                        r_retire_tag   <= w_sel_tag;
                        r_wr_addr      <= w_sel_addr;
                        r_wr_data      <= w_sel_data;
                        if (w_sel_addr != 5'd0) begin
                            r_we     <= 1'b1;
                            r_unlock <= 32'd1 << w_sel_addr;
                        end
                    end
                end
                c_S_FLUSH: begin
                    if (!flush && (req_valid == '0)) begin
                        r_state <= c_S_RUN;
                    end
                end
                default: r_state <= c_S_RUN;
            endcase
        end
    end

    assign we           = r_we;
    assign wr_addr      = r_wr_addr;
    assign wr_data      = r_wr_data;
    assign unlock       = r_unlock;
    assign retire_valid = r_retire_valid;
    assign retire_tag   = r_retire_tag;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter
// Purpose  : Self-checking bench for wb_arbiter with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

    localparam int N  = 4;
    localparam int TW = 4;
`ifdef WB_TAG_ORDER_EN
    localparam bit ORDERED = 1'b1;
`else
    localparam bit ORDERED = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*5-1:0]  req_addr;
    logic [N*32-1:0] req_data;
    logic [N*TW-1:0] req_tag;
    logic            flush;
    logic [TW-1:0]   flush_tag;
    logic            we;
    logic [4:0]      wr_addr;
    logic [31:0]     wr_data;
    logic [31:0]     unlock;
    logic            retire_valid;
    logic [TW-1:0]   retire_tag;
    logic [TW-1:0]   exp_tag;

    always #5 clk = ~clk;

    wb_arbiter #(.N_REQ(N), .TAG_W(TW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_tag(req_tag),
        .flush(flush), .flush_tag(flush_tag),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .unlock(unlock),
        .retire_valid(retire_valid), .retire_tag(retire_tag), .exp_tag(exp_tag)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit            m_flushing;
    int            m_last;
    logic [TW-1:0] m_exp;
    int            m_grant;
    logic [N-1:0]  e_ready;
    logic [N-1:0]  obs_ready;
    logic          e_we;
    logic [4:0]    e_addr;
    logic [31:0]   e_data;
    logic [31:0]   e_unlock;
    logic          e_rv;
    logic [TW-1:0] e_rtag;

    logic [1+5+32+32+1+TW+TW-1:0] obs_vec, exp_vec;
    assign obs_vec = {we, we ? wr_addr : 5'd0, we ? wr_data : 32'd0, unlock,
                      retire_valid, retire_tag, exp_tag};
    assign exp_vec = {e_we, e_addr, e_data, e_unlock, e_rv, e_rtag, m_exp};

    task automatic set_unit(input int k, input bit v, input logic [4:0] a,
                            input logic [31:0] d, input logic [TW-1:0] t);
        req_valid[k]         = v;
        req_addr[k*5 +: 5]   = a;
        req_data[k*32 +: 32] = d;
        req_tag[k*TW +: TW]  = t;
    endtask

    task automatic clear_all();
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        req_tag   = '0;
        flush     = 1'b0;
        flush_tag = '0;
    endtask

    // Who should be granted: the eligible unit closest after the last winner.
    task automatic model_comb();
        int best, bestd, d;
        e_ready = '0;
        m_grant = -1;
        if (reset) begin
            e_ready = '0;
        end else if (m_flushing) begin
            e_ready = req_valid;
        end else if (!flush) begin
            best  = -1;
            bestd = N;
            for (int k = 0; k < N; k++) begin
                if (req_valid[k] && (!ORDERED || req_tag[k*TW +: TW] == m_exp)) begin
                    d = (((k - m_last - 1) % N) + N) % N;
                    if (d < bestd) begin
                        bestd = d;
                        best  = k;
                    end
                end
            end
            m_grant = best;
            if (best >= 0) e_ready[best] = 1'b1;
        end
    endtask

    task automatic model_seq();
        logic [4:0] a;
        e_we = 0; e_addr = 0; e_data = 0; e_unlock = 0; e_rv = 0; e_rtag = 0;
        if (reset) begin
            m_flushing = 0;
            m_last     = N - 1;
            m_exp      = '0;
        end else if (m_flushing) begin
            if (flush) begin
                if (ORDERED) m_exp = flush_tag;
            end else if (req_valid == '0) begin
                m_flushing = 0;
            end
        end else if (flush) begin
            m_flushing = 1;
            if (ORDERED) m_exp = flush_tag;
        end else if (m_grant >= 0) begin
            a      = req_addr[m_grant*5 +: 5];
            e_rv   = 1'b1;
            e_rtag = req_tag[m_grant*TW +: TW];
            if (a != 5'd0) begin
                e_we     = 1'b1;
                e_addr   = a;
                e_data   = req_data[m_grant*32 +: 32];
                e_unlock = 32'd1 << a;
            end
            m_last = m_grant;
            if (ORDERED) m_exp = TW'((int'(m_exp) + 1) % (1 << TW));
        end
    endtask

    // One clock: ready sampled mid-cycle, outputs valid #1 after the edge.
    task automatic tick();
        @(negedge clk);
        model_comb();
        obs_ready = req_ready;
        @(posedge clk);
        model_seq();
        #1;
    endtask

    task automatic test_reset();
        clear_all();
        reset = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (obs_ready !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_ready: got %b want 0000", obs_ready);
        end
        n_cmp++;
        if ({we, wr_addr, wr_data, unlock, retire_valid, retire_tag, exp_tag} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got we=%b addr=%h data=%h unlock=%h rv=%b rtag=%h exp=%h want all 0",
                     we, wr_addr, wr_data, unlock, retire_valid, retire_tag, exp_tag);
        end
        reset = 1'b0;
    endtask

    task automatic test_round_robin();
        int seq[5] = '{0, 1, 2, 3, 0};
        logic [TW-1:0] base;
        logic [N-1:0] want;
        base = m_exp;
        for (int k = 0; k < N; k++) set_unit(k, 1, 5'(k + 1), $urandom, TW'(base + k));
        for (int i = 0; i < 5; i++) begin
            tick();
            want = '0;
            want[seq[i]] = 1'b1;
            n_cmp++;
            if (obs_ready !== want) begin
                n_bad++;
                $display("FAIL rr_grant_%0d: got %b want %b", i, obs_ready, want);
            end
            n_cmp++;
            if (obs_vec !== exp_vec || we !== 1'b1) begin
                n_bad++;
                $display("FAIL rr_out_%0d: got %h want %h (we=%b)", i, obs_vec, exp_vec, we);
            end
            if (i == 0) set_unit(0, 1, 5'd9, $urandom, TW'(base + 4));
            else        req_valid[seq[i]] = 1'b0;
        end
        clear_all();
        tick();
    endtask

    task automatic test_write_x5();
        clear_all();
        set_unit(2, 1, 5'd5, 32'hDEADBEEF, m_exp);
        tick();
        clear_all();
        n_cmp++;
        if (obs_ready !== 4'b0100) begin
            n_bad++;
            $display("FAIL x5_ready: got %b want 0100", obs_ready);
        end
        n_cmp++;
        if ({we, wr_addr, wr_data, unlock} !== {1'b1, 5'd5, 32'hDEADBEEF, 32'h0000_0020}) begin
            n_bad++;
            $display("FAIL x5_write: got we=%b addr=%0d data=%h unlock=%h want 1/5/deadbeef/00000020",
                     we, wr_addr, wr_data, unlock);
        end
        tick();
        n_cmp++;
        if (we !== 1'b0 || obs_vec !== exp_vec) begin
            n_bad++;
            $display("FAIL x5_idle: got %h want %h", obs_vec, exp_vec);
        end
    endtask

    task automatic test_addr0();
        logic [TW-1:0] t;
        t = m_exp;
        set_unit(1, 1, 5'd0, 32'h1234_5678, t);
        tick();
        clear_all();
        n_cmp++;
        if ({retire_valid, we, unlock, retire_tag} !== {1'b1, 1'b0, 32'd0, t}) begin
            n_bad++;
            $display("FAIL addr0: got rv=%b we=%b unlock=%h rtag=%h want 1/0/0/%h",
                     retire_valid, we, unlock, retire_tag, t);
        end
        tick();
    endtask

`ifdef WB_TAG_ORDER_EN
    task automatic test_ordered();
        clear_all();
        flush = 1; flush_tag = 4'd3;
        tick();
        clear_all();
        tick();
        n_cmp++;
        if (exp_tag !== 4'd3) begin
            n_bad++;
            $display("FAIL ord_load: got %h want 3", exp_tag);
        end
        set_unit(1, 1, 5'd7, 32'h11, 4'd4);
        set_unit(2, 1, 5'd8, 32'h22, 4'd3);
        tick();
        n_cmp++;
        if (obs_ready !== 4'b0100) begin
            n_bad++;
            $display("FAIL ord_first: got %b want 0100", obs_ready);
        end
        req_valid[2] = 1'b0;
        tick();
        n_cmp++;
        if (obs_ready !== 4'b0010) begin
            n_bad++;
            $display("FAIL ord_second: got %b want 0010", obs_ready);
        end
        clear_all();
        n_cmp++;
        if (exp_tag !== 4'd5) begin
            n_bad++;
            $display("FAIL ord_exp: got %h want 5", exp_tag);
        end
        // wrap 15 -> 0
        flush = 1; flush_tag = 4'd15;
        tick();
        clear_all();
        tick();
        set_unit(0, 1, 5'd3, 32'h33, 4'd15);
        tick();
        set_unit(0, 1, 5'd4, 32'h44, 4'd0);
        n_cmp++;
        if (exp_tag !== 4'd0) begin
            n_bad++;
            $display("FAIL wrap_exp0: got %h want 0", exp_tag);
        end
        tick();
        clear_all();
        n_cmp++;
        if (exp_tag !== 4'd1 || obs_ready !== 4'b0001) begin
            n_bad++;
            $display("FAIL wrap_exp1: got exp=%h ready=%b want 1/0001", exp_tag, obs_ready);
        end
        tick();
    endtask
`endif

    task automatic test_flush();
        logic [TW-1:0] want_exp;
`ifdef WB_TAG_ORDER_EN
        want_exp = 4'd9;
`else
        want_exp = 4'd0;
`endif
        clear_all();
        set_unit(0, 1, 5'd10, 32'hAA, TW'(m_exp + 7));
        set_unit(3, 1, 5'd11, 32'hBB, TW'(m_exp + 8));
        flush = 1; flush_tag = 4'd9;
        tick();
        flush = 0;
        n_cmp++;
        if (obs_ready !== 4'b0000) begin
            n_bad++;
            $display("FAIL flush_wins: got %b want 0000", obs_ready);
        end
        tick();
        n_cmp++;
        if (obs_ready !== 4'b1001 || we !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_drain: got ready=%b we=%b want 1001/0", obs_ready, we);
        end
        clear_all();
        tick();
        n_cmp++;
        if ({we, unlock, retire_valid, exp_tag} !== {1'b0, 32'd0, 1'b0, want_exp}) begin
            n_bad++;
            $display("FAIL flush_idle: got we=%b unlock=%h rv=%b exp=%h want 0/0/0/%h",
                     we, unlock, retire_valid, exp_tag, want_exp);
        end
        set_unit(1, 1, 5'd12, 32'hCC, want_exp);
        tick();
        clear_all();
        n_cmp++;
        if (obs_ready !== 4'b0010 || we !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_resume: got ready=%b we=%b want 0010/1", obs_ready, we);
        end
        tick();
    endtask

    task automatic test_reset_midstream();
        clear_all();
        for (int k = 0; k < N; k++) set_unit(k, 1, 5'(k + 20), $urandom, TW'(m_exp + k));
        tick();
        for (int k = 0; k < N; k++) if (obs_ready[k]) req_valid[k] = 1'b0;
        tick();
        for (int k = 0; k < N; k++) set_unit(k, 1, 5'(k + 20), $urandom, TW'(k));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if (obs_ready !== 4'b0000) begin
            n_bad++;
            $display("FAIL rst_mid_ready: got %b want 0000", obs_ready);
        end
        n_cmp++;
        if ({we, wr_addr, wr_data, unlock, retire_valid, retire_tag, exp_tag} !== '0) begin
            n_bad++;
            $display("FAIL rst_mid_out: got %h want 0", obs_vec);
        end
        tick();
        clear_all();
        n_cmp++;
        if (obs_ready !== 4'b0001) begin
            n_bad++;
            $display("FAIL rst_mid_first: got %b want 0001", obs_ready);
        end
        tick();
    endtask

    task automatic test_random();
        clear_all();
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!req_valid[k] && $urandom_range(0, 2) == 0)
                    set_unit(k, 1, 5'($urandom_range(0, 31)), $urandom,
                             TW'(int'(m_exp) + $urandom_range(0, 3)));
            end
            flush     = ($urandom_range(0, 15) == 0);
            flush_tag = TW'($urandom);
            tick();
            n_cmp++;
            if (obs_ready !== e_ready) begin
                n_bad++;
                $display("FAIL rnd_ready_%0d: got %b want %b", c, obs_ready, e_ready);
            end
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_bad++;
                $display("FAIL rnd_out_%0d: got %h want %h", c, obs_vec, exp_vec);
            end
            for (int k = 0; k < N; k++) if (req_valid[k] && obs_ready[k]) req_valid[k] = 1'b0;
        end
        clear_all();
        tick();
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        clear_all();
        test_reset();
        test_round_robin();
        test_write_x5();
        test_addr0();
`ifdef WB_TAG_ORDER_EN
        test_ordered();
`endif
        test_flush();
        test_reset_midstream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
